fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue_if.sv | 62 ++++++
 rtl/fetch_decode_queue.sv | 94 +++++++++
 tb/tb_fetch_decode_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_queue_if.sv
// Shared types and the fetch/decode handshake bundle for the fetch-to-decode packet queue.
// The queue is the slave; whoever drives fetch packets and consumes decode packets is the master.
package fdq_pkg;
  typedef logic [31:0] inst_t;

  localparam logic [3:0] CAUSE_ILLEGAL_INSTRUCTION = 4'd2;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] pc_pred;
    logic        pred_taken;
    inst_t       inst;
    trap_req_t   trap_req;
  } fdq_entry_t;
endpackage

interface fdq_if #(parameter int DEPTH = 4) ();
  import fdq_pkg::*;

  logic        valid_f;
  logic        ready_f;
  logic [31:0] pc_f;
  logic [31:0] pcplus4_f;
  logic [31:0] pc_pred_f;
  logic        pred_taken_f;
  inst_t       inst_f;
  trap_req_t   trap_req_f;
  logic        flush;

  logic        ready_d;
  logic        valid_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic [31:0] pc_pred_d;
  logic        pred_taken_d;
  inst_t       inst_d;
  trap_req_t   trap_req_d;

  logic [$clog2(DEPTH+1)-1:0] count;
  logic        almost_full;
  logic        sealed;

  modport slave (
    input  valid_f, pc_f, pcplus4_f, pc_pred_f, pred_taken_f, inst_f, trap_req_f, flush, ready_d,
    output ready_f, valid_d, pc_d, pcplus4_d, pc_pred_d, pred_taken_d, inst_d, trap_req_d,
           count, almost_full, sealed
  );

  modport master (
    output valid_f, pc_f, pcplus4_f, pc_pred_f, pred_taken_f, inst_f, trap_req_f, flush, ready_d,
    input  ready_f, valid_d, pc_d, pcplus4_d, pc_pred_d, pred_taken_d, inst_d, trap_req_d,
           count, almost_full, sealed
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular buffer of fetch packets between fetch and decode. Seals after queuing a trapping packet
// until flushed; decode outputs read combinationally from the head and forced to zero when empty.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic  clk,
  input  logic  start,
  fdq_if.slave  bus
);
  import fdq_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

  fdq_entry_t    mem [DEPTH];
  fdq_entry_t    wr_entry;
  fdq_entry_t    head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          sealed_q;
  logic          run_q;
  logic          ready_f_int;
  logic          valid_d_int;
  logic          push;
  logic          pop;

  // run_q keeps ready_f low while in reset and until the first edge after release.
  assign ready_f_int = run_q && (count_q < DEPTH_C) && !sealed_q;
  assign valid_d_int = (count_q != '0);
  assign push        = bus.valid_f && ready_f_int && !bus.flush;
  assign pop         = valid_d_int && bus.ready_d && !bus.flush;

  always_comb begin
    wr_entry            = '0;
    wr_entry.pc         = bus.pc_f;
    wr_entry.pcplus4    = bus.pcplus4_f;
    wr_entry.pc_pred    = bus.pc_pred_f;
    wr_entry.pred_taken = bus.pred_taken_f;
    wr_entry.inst       = bus.inst_f;
    wr_entry.trap_req   = bus.trap_req_f;
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      sealed_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (bus.flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count_q  <= '0;
        sealed_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          if (bus.trap_req_f.valid) sealed_q <= 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_comb begin
    head = '0;
    if (valid_d_int) head = mem[rd_ptr];
  end

  assign bus.ready_f      = ready_f_int;
  assign bus.valid_d      = valid_d_int;
  assign bus.pc_d         = head.pc;
  assign bus.pcplus4_d    = head.pcplus4;
  assign bus.pc_pred_d    = head.pc_pred;
  assign bus.pred_taken_d = head.pred_taken;
  assign bus.inst_d       = head.inst;
  assign bus.trap_req_d   = head.trap_req;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.sealed       = sealed_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed scenario bench for fetch_decode_queue (DEPTH=4, AFULL=3).
module tb_fetch_decode_queue;
  import fdq_pkg::*;

  logic clk;
  logic start;
  int   errors;
  int   checks;

  fdq_if #(.DEPTH(4)) bus ();

  fetch_decode_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_f      = 1'b0;
    bus.pc_f         = '0;
    bus.pcplus4_f    = '0;
    bus.pc_pred_f    = '0;
    bus.pred_taken_f = 1'b0;
    bus.inst_f       = '0;
    bus.trap_req_f   = '0;
    bus.flush        = 1'b0;
    bus.ready_d      = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc);
    bus.valid_f      = 1'b1;
    bus.pc_f         = pc;
    bus.pcplus4_f    = pc + 32'd4;
    bus.pc_pred_f    = pc + 32'd8;
    bus.pred_taken_f = pc[2];
    bus.inst_f       = {pc[15:0], 16'h0013};
    bus.trap_req_f   = '0;
  endtask

  task automatic test_reset();
    idle();
    start = 1'b0;
    #2;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid_d: got %b want 0", bus.valid_d); end
    checks++; if (bus.ready_f !== 1'b0) begin errors++; $display("FAIL reset_ready_f: got %b want 0", bus.ready_f); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", bus.almost_full); end
    checks++; if (bus.sealed !== 1'b0) begin errors++; $display("FAIL reset_sealed: got %b want 0", bus.sealed); end
    checks++; if (bus.inst_d !== 32'h0 || bus.pc_d !== 32'h0) begin errors++; $display("FAIL reset_d_zero: inst %h pc %h want 0", bus.inst_d, bus.pc_d); end
    start = 1'b1;
    #1;
    checks++; if (bus.ready_f !== 1'b0) begin errors++; $display("FAIL pre_edge_ready_f: got %b want 0", bus.ready_f); end
    tick();
    checks++; if (bus.ready_f !== 1'b1) begin errors++; $display("FAIL post_edge_ready_f: got %b want 1", bus.ready_f); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] pc;
    idle();
    offer(32'h100);
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL no_bypass: valid_d %b want 0", bus.valid_d); end
    for (int i = 0; i < 4; i++) begin
      offer(32'h100 + 32'(4 * i));
      tick();
      if (i == 1) begin
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL afull_at2: got %b want 0", bus.almost_full); end
      end
      if (i == 2) begin
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL afull_at3: got %b want 1", bus.almost_full); end
      end
    end
    bus.valid_f = 1'b0;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", bus.count); end
    checks++; if (bus.ready_f !== 1'b0) begin errors++; $display("FAIL fill_ready_f: got %b want 0", bus.ready_f); end
    checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL fill_afull: got %b want 1", bus.almost_full); end
    bus.ready_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 + 32'(4 * i);
      checks++; if (bus.pc_d !== pc) begin errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, bus.pc_d, pc); end
      checks++;
      if (bus.pcplus4_d !== pc + 32'd4 || bus.pc_pred_d !== pc + 32'd8 || bus.pred_taken_d !== pc[2]
          || bus.inst_d !== {pc[15:0], 16'h0013}) begin
        errors++; $display("FAIL drain_payload[%0d]: pc4 %h pred %h tk %b inst %h", i, bus.pcplus4_d, bus.pc_pred_d, bus.pred_taken_d, bus.inst_d);
      end
      tick();
    end
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL drained_valid_d: got %b want 0", bus.valid_d); end
    checks++; if (bus.inst_d !== 32'h0 || bus.pc_d !== 32'h0) begin errors++; $display("FAIL drained_bubble: inst %h pc %h want 0", bus.inst_d, bus.pc_d); end
    bus.ready_d = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    idle();
    offer(32'h200); tick();
    offer(32'h204); tick();
    bus.ready_d = 1'b1;
    for (int k = 0; k < 10; k++) begin
      offer(32'h208 + 32'(4 * k));
      exp_pc = 32'h200 + 32'(4 * k);
      checks++; if (bus.pc_d !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, bus.pc_d, exp_pc); end
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 2", k, bus.count); end
      tick();
    end
    bus.valid_f = 1'b0;
    for (int k = 10; k < 12; k++) begin
      exp_pc = 32'h200 + 32'(4 * k);
      checks++; if (bus.pc_d !== exp_pc) begin errors++; $display("FAIL wrap_tail[%0d]: got %h want %h", k, bus.pc_d, exp_pc); end
      tick();
    end
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL wrap_empty: valid_d %b want 0", bus.valid_d); end
    bus.ready_d = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc;
    idle();
    for (int i = 0; i < 4; i++) begin
      offer(32'h300 + 32'(4 * i));
      tick();
    end
    offer(32'h3F0);
    bus.ready_d = 1'b1;
    checks++; if (bus.ready_f !== 1'b0) begin errors++; $display("FAIL full_pop_ready_f: got %b want 0", bus.ready_f); end
    tick();
    bus.valid_f = 1'b0;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d want 3", bus.count); end
    for (int i = 1; i < 4; i++) begin
      exp_pc = 32'h300 + 32'(4 * i);
      checks++; if (bus.pc_d !== exp_pc) begin errors++; $display("FAIL full_pop_drain[%0d]: got %h want %h", i, bus.pc_d, exp_pc); end
      tick();
    end
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL full_pop_dropped: valid_d %b want 0", bus.valid_d); end
    bus.ready_d = 1'b0;
  endtask

  task automatic test_trap_seal();
    trap_req_t exp_trap;
    idle();
    exp_trap.valid = 1'b1;
    exp_trap.cause = CAUSE_ILLEGAL_INSTRUCTION;
    exp_trap.pc    = 32'h404;
    exp_trap.tval  = 32'hDEADBEEF;
    offer(32'h400); tick();
    offer(32'h404);
    bus.trap_req_f = exp_trap;
    tick();
    offer(32'h408);
    checks++; if (bus.sealed !== 1'b1) begin errors++; $display("FAIL trap_sealed: got %b want 1", bus.sealed); end
    checks++; if (bus.ready_f !== 1'b0) begin errors++; $display("FAIL trap_ready_f: got %b want 0", bus.ready_f); end
    tick();
    bus.valid_f = 1'b0;
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL trap_blocked_count: got %0d want 2", bus.count); end
    bus.ready_d = 1'b1;
    checks++; if (bus.pc_d !== 32'h400 || bus.trap_req_d.valid !== 1'b0) begin errors++; $display("FAIL trap_head0: pc %h trap %b", bus.pc_d, bus.trap_req_d.valid); end
    tick();
    checks++; if (bus.pc_d !== 32'h404) begin errors++; $display("FAIL trap_head1_pc: got %h want 404", bus.pc_d); end
    checks++; if (bus.trap_req_d !== exp_trap) begin errors++; $display("FAIL trap_payload: got %h want %h", bus.trap_req_d, exp_trap); end
    tick();
    bus.ready_d = 1'b0;
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL trap_drained: valid_d %b want 0", bus.valid_d); end
    checks++; if (bus.sealed !== 1'b1 || bus.ready_f !== 1'b0) begin errors++; $display("FAIL trap_stays_sealed: sealed %b ready_f %b", bus.sealed, bus.ready_f); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.sealed !== 1'b0 || bus.ready_f !== 1'b1) begin errors++; $display("FAIL trap_unsealed: sealed %b ready_f %b", bus.sealed, bus.ready_f); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin
      offer(32'h500 + 32'(4 * i));
      tick();
    end
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", bus.count); end
    offer(32'h5F0);
    bus.ready_d = 1'b1;
    bus.flush   = 1'b1;
    checks++; if (bus.pc_d !== 32'h500 || bus.valid_d !== 1'b1) begin errors++; $display("FAIL flush_cycle_head: pc %h valid %b", bus.pc_d, bus.valid_d); end
    tick();
    idle();
    checks++; if (bus.count !== 3'd0 || bus.valid_d !== 1'b0) begin errors++; $display("FAIL flush_empty: count %0d valid_d %b", bus.count, bus.valid_d); end
    checks++; if (bus.sealed !== 1'b0 || bus.ready_f !== 1'b1) begin errors++; $display("FAIL flush_ready: sealed %b ready_f %b", bus.sealed, bus.ready_f); end
    tick();
    checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL flush_dropped: valid_d %b want 0", bus.valid_d); end
  endtask

  task automatic test_async_reset();
    idle();
    offer(32'h600); tick();
    offer(32'h604); tick();
    bus.valid_f = 1'b0;
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL arst_pre_count: got %0d want 2", bus.count); end
    #3;
    start = 1'b0;
    #1;
    checks++; if (bus.valid_d !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL arst_immediate: valid_d %b count %0d", bus.valid_d, bus.count); end
    checks++; if (bus.ready_f !== 1'b0 || bus.pc_d !== 32'h0) begin errors++; $display("FAIL arst_outputs: ready_f %b pc_d %h", bus.ready_f, bus.pc_d); end
    #1;
    start = 1'b1;
    tick();
    checks++; if (bus.ready_f !== 1'b1 || bus.count !== 3'd0) begin errors++; $display("FAIL arst_release: ready_f %b count %0d", bus.ready_f, bus.count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_trap_seal();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
